// File: rtl/seq_divider16.sv
// Sequential 16-bit restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; default is unsigned.
module seq_divider16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    input  logic        sel,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [15:0] disp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_div;
    logic [15:0] r_rem;
    logic [15:0] r_shreg;
    logic [3:0]  r_cnt;
    logic        w_accept;
    logic        w_zero;
    logic        w_ge;
    logic [15:0] w_shift;
    logic [15:0] w_rem_nx;
    logic [15:0] w_q_nx;
    logic [15:0] w_mag_a;
    logic [15:0] w_mag_b;
    logic [15:0] w_q_fix;
    logic [15:0] w_r_fix;

    assign w_accept = start && (r_state != S_CALC);
    assign w_zero   = (divisor == 16'd0);

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_mag_a = dividend[15] ? (~dividend + 16'd1) : dividend;
    assign w_mag_b = divisor[15]  ? (~divisor + 16'd1)  : divisor;
    assign w_q_fix = r_neg_q ? (~w_q_nx + 16'd1) : w_q_nx;
    assign w_r_fix = r_neg_r ? (~w_rem_nx + 16'd1) : w_rem_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= dividend[15] ^ divisor[15];
            r_neg_r <= dividend[15];
        end
    end
`else
    assign w_mag_a = dividend;
    assign w_mag_b = divisor;
    assign w_q_fix = w_q_nx;
    assign w_r_fix = w_rem_nx;
`endif

    // Partial remainder is always below the divisor, so 16 bits hold it.
    assign w_ge     = {r_rem, r_shreg[15]} >= {1'b0, r_div};
    assign w_shift  = {r_rem[14:0], r_shreg[15]};
    assign w_rem_nx = w_ge ? (w_shift - r_div) : w_shift;
    assign w_q_nx   = {r_shreg[14:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next = w_zero ? S_DONE : S_CALC;
                else       w_next = S_IDLE;
            end
            S_CALC: begin
                if (r_cnt == 4'd15) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            S_CALC:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= 16'd0;
            r_rem       <= 16'd0;
            r_shreg     <= 16'd0;
            r_cnt       <= 4'd0;
            quotient    <= 16'd0;
            remainder   <= 16'd0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_div <= w_mag_b;
            if (w_zero) begin
                quotient    <= 16'hFFFF;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
                r_rem       <= 16'd0;
                r_shreg     <= w_mag_a;
                r_cnt       <= 4'd0;
            end
        end else if (r_state == S_CALC) begin
            r_rem   <= w_rem_nx;
            r_shreg <= w_q_nx;
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
                quotient  <= w_q_fix;
                remainder <= w_r_fix;
            end
        end
    end

    assign disp = sel ? remainder : quotient;

endmodule
